// File: rtl/sram_dump_reader.sv
// Streams a contiguous SRAM window out through a valid/ready port.
// Reads are throttled so that buffered plus in-flight words never exceed the 2-entry FIFO.
module sram_dump_reader #(
    parameter int D_WIDTH  = 32,
    parameter int SA_WIDTH = 5
) (
    input  logic                Clk,
    input  logic                Rst,
    input  logic                Str,
    input  logic [SA_WIDTH-1:0] Base,
    input  logic [SA_WIDTH:0]   Len,
    output logic [SA_WIDTH-1:0] Addr,
    output logic                En,
    output logic                RW,
    input  logic [D_WIDTH-1:0]  Data_O,
    output logic [D_WIDTH-1:0]  Out_Data,
    output logic                Out_Valid,
    input  logic                Out_Ready,
    output logic                Busy,
    output logic                Done
);

    typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_DONE} state_t;

    localparam logic [SA_WIDTH:0] ONE = 1;

    state_t               state, state_nxt;
    logic [SA_WIDTH:0]    remaining;
    logic                 inflight;
    logic [1:0]           cnt;
    logic [1:0]           occ;
    logic [D_WIDTH-1:0]   head, tail;
    logic                 pop, push, accept;

    assign RW        = 1'b0;
    assign Out_Valid = (cnt != 2'd0);
    assign Out_Data  = head;
    assign Busy      = (state == S_READ) || (state == S_DRAIN);
    assign Done      = (state == S_DONE);

    assign pop  = Out_Valid && Out_Ready;
    assign push = inflight;
    // Occupancy never exceeds 2, so a pop is the only way to free a full slot.
    assign occ  = cnt + {1'b0, inflight};

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) state <= S_IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        En        = 1'b0;
        accept    = 1'b0;
        case (state)
            S_IDLE, S_DONE: begin
                if (Str) begin
                    accept    = 1'b1;
                    state_nxt = (Len == '0) ? S_DONE : S_READ;
                end
            end
            S_READ: begin
                if (remaining != '0 && (occ < 2'd2 || pop)) begin
                    En = 1'b1;
                    if (remaining == ONE) state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (cnt == 2'd0 && !inflight) state_nxt = S_DONE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            Addr      <= '0;
            remaining <= '0;
            inflight  <= 1'b0;
            cnt       <= 2'd0;
            head      <= '0;
            tail      <= '0;
        end else begin
            if (accept) begin
                Addr      <= Base;
                remaining <= Len;
            end else if (En) begin
                Addr      <= Addr + 1'b1;
                remaining <= remaining - 1'b1;
            end
            inflight <= En;

            // head is the registered stream output; tail only holds the second word.
            case ({push, pop})
                2'b10: begin
                    if (cnt == 2'd0) head <= Data_O;
                    else             tail <= Data_O;
                    cnt <= cnt + 2'd1;
                end
                2'b01: begin
                    head <= tail;
                    cnt  <= cnt - 2'd1;
                end
                2'b11: begin
                    if (cnt == 2'd1) begin
                        head <= Data_O;
                    end else begin
                        head <= tail;
                        tail <= Data_O;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sram_dump_reader.sv
// Randomized bench for sram_dump_reader: SRAM model, queue-based expected stream,
// per-cycle checks of issue budget, addresses, ordering and hold-under-backpressure.
module tb_sram_dump_reader;

    logic        Clk, Rst, Str, En, RW, Out_Valid, Out_Ready, Busy, Done;
    logic [4:0]  Base, Addr;
    logic [5:0]  Len;
    logic [31:0] Data_O = '0;
    logic [31:0] Out_Data;

    sram_dump_reader #(.D_WIDTH(32), .SA_WIDTH(5)) dut (
        .Clk(Clk), .Rst(Rst), .Str(Str), .Base(Base), .Len(Len),
        .Addr(Addr), .En(En), .RW(RW), .Data_O(Data_O),
        .Out_Data(Out_Data), .Out_Valid(Out_Valid), .Out_Ready(Out_Ready),
        .Busy(Busy), .Done(Done)
    );

    logic [31:0] mem [32];
    logic [31:0] exp_q[$];
    logic [31:0] got[$];
    int vec = 0, err = 0, cyc = 0;
    int m_base, m_len, issued, xfer, c0, rmode;
    bit act = 0, first_seen, prev_hold;
    logic [31:0] prev_data;

    initial begin
        Clk = 0;
        forever #5 Clk = ~Clk;
    end

    always @(posedge Clk) cyc <= cyc + 1;

    // Synchronous-read SRAM: data appears the cycle after the sampling edge.
    always @(posedge Clk) if (En) Data_O <= mem[Addr];

    task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
        vec++;
        if (a !== e) begin
            err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, a, e, cyc);
        end
    endtask

    initial begin
        rmode = 0;
        Out_Ready = 1'b1;
        forever begin
            @(posedge Clk); #1;
            case (rmode)
                1:       Out_Ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
                2:       Out_Ready = 1'($urandom_range(0, 1));
                default: Out_Ready = 1'b1;
            endcase
        end
    end

    always @(negedge Clk) begin
        chk("rw", RW, 0);
        if (!act) begin
            chk("idle_en", En, 0);
            chk("idle_valid", Out_Valid, 0);
        end else begin
            if (m_len > 0 && xfer < m_len) begin
                chk("busy", Busy, 1);
                chk("done_early", Done, 0);
            end
            if (m_len == 0) begin
                chk("busy_len0", Busy, 0);
                chk("done_len0", Done, 1);
            end
            if (En) begin
                chk("en_remaining", issued < m_len, 1);
                chk("addr", 32'(Addr), (m_base + issued) % 32);
                chk("en_slot", (issued - xfer - ((Out_Valid && Out_Ready) ? 1 : 0)) < 2, 1);
                issued++;
            end
            if (Out_Valid) begin
                if (!first_seen) begin
                    chk("latency", cyc - c0, 2);
                    first_seen = 1;
                end
                if (prev_hold) chk("hold_data", Out_Data, prev_data);
                if (xfer < m_len) chk("data", Out_Data, exp_q[xfer]);
                else              chk("extra_word", xfer, m_len - 1);
                if (Out_Ready) begin
                    got.push_back(Out_Data);
                    xfer++;
                end
            end else if (prev_hold) begin
                chk("valid_dropped", Out_Valid, 1);
            end
            prev_hold = Out_Valid && !Out_Ready;
            prev_data = Out_Data;
        end
    end

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_addr"}, 32'(Addr), 0);
        chk({tag, "_en"}, En, 0);
        chk({tag, "_valid"}, Out_Valid, 0);
        chk({tag, "_data"}, Out_Data, 0);
        chk({tag, "_busy"}, Busy, 0);
        chk({tag, "_done"}, Done, 0);
    endtask

    task automatic xact(input int base, input int len, input int mode,
                        input int glitch, input int abort_n);
        int k;
        m_base = base; m_len = len;
        exp_q.delete(); got.delete();
        for (int i = 0; i < len; i++) exp_q.push_back(mem[(base + i) % 32]);
        issued = 0; xfer = 0; first_seen = 0; prev_hold = 0;
        rmode = mode;
        Str = 1; Base = 5'(base); Len = 6'(len);
        @(posedge Clk); #1;
        Str = 0; act = 1; c0 = cyc;
        if (len == 0) begin
            repeat (3) @(posedge Clk);
            #1 act = 0;
            return;
        end
        k = 0;
        while (xfer < len && k < 2000) begin
            @(posedge Clk); #1;
            k++;
            if (k == glitch) begin
                Str = 1; Base = 5'(base + 11); Len = 6'd3;
            end else begin
                Str = 0;
            end
            if (abort_n > 0 && xfer == abort_n) begin
                act = 0;
                Rst = 0;
                #1 chk_reset_outputs("abort");
                repeat (2) @(posedge Clk);
                #1 Rst = 1;
                return;
            end
        end
        Str = 0;
        chk("timeout", xfer, len);
        if (mode == 0) chk("last_edge", cyc - c0, len + 2);
        chk("valid_after_last", Out_Valid, 0);
        chk("done_lag", Done, 0);
        @(posedge Clk); #1;
        chk("done_final", Done, 1);
        chk("busy_final", Busy, 0);
        chk("word_count", got.size(), len);
        act = 0;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = 32'h1000_0000 + i;
        Rst = 0; Str = 0; Base = '0; Len = '0;
        #1 chk_reset_outputs("reset");
        repeat (2) @(posedge Clk);
        #1 Rst = 1;
        @(posedge Clk); #1;

        // Len=0 from idle: straight to done, never enables the SRAM
        chk("pre_len0_done", Done, 0);
        xact(7, 0, 0, 0, 0);

        xact(0, 32, 0, 0, 0);
        chk("full_first", got[0], 32'h1000_0000);
        chk("full_last", got[31], 32'h1000_001F);

        xact(30, 4, 0, 0, 0);
        chk("wrap_0", got[0], 32'h1000_001E);
        chk("wrap_1", got[1], 32'h1000_001F);
        chk("wrap_2", got[2], 32'h1000_0000);
        chk("wrap_3", got[3], 32'h1000_0001);

        xact(12, 8, 1, 0, 0);
        chk("bp_first", got[0], 32'h1000_000C);
        chk("bp_last", got[7], 32'h1000_0013);

        xact(3, 8, 0, 2, 0);
        chk("glitch_first", got[0], 32'h1000_0003);
        chk("glitch_last", got[7], 32'h1000_000A);

        xact(0, 10, 0, 0, 3);
        @(posedge Clk); #1;
        xact(5, 2, 0, 0, 0);
        chk("restart_0", got[0], 32'h1000_0005);
        chk("restart_1", got[1], 32'h1000_0006);

        for (int t = 0; t < 8; t++) begin
            for (int i = 0; i < 32; i++) mem[i] = $urandom;
            xact($urandom_range(0, 31), $urandom_range(1, 32), $urandom_range(0, 2), 0, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec, err);
        $finish;
    end

endmodule

// File: doc/sram_dump_reader.md
# sram_dump_reader

Read-side counterpart to the SRAM write-load path of the GPP top level. After the GPP asserts Done, or on any host Str request, this block walks a contiguous SRAM window through the shared Addr/En/RW/Data_O port. It returns each word on a valid/ready output stream, buffered so downstream backpressure never drops or duplicates data. It is used for data-memory dumps and load verification.

## Interface
- D_WIDTH, 32, SRAM word width (matches `D_WIDTH).
- SA_WIDTH, 5, SRAM address width (matches `SA_WIDTH).
- Clk  in  1  system clock, all state on rising edge.
- Rst  in  1  asynchronous, active-low reset: one clock; reset is asynchronous and active-low.
- Str  in  1  start request, sampled only in S_IDLE/S_DONE.
- Base  in  SA_WIDTH  first address, captured on accepted Str.
- Len  in  SA_WIDTH+1  word count (0..2^SA_WIDTH), captured on accepted Str.
- Addr  out  SA_WIDTH  SRAM address.
- En  out  1  SRAM enable (read strobe).
- RW  out  1  SRAM direction, constant 0 (read).
- Data_O  in  D_WIDTH  SRAM read data, valid the cycle after the edge that sampled En=1.
- Out_Data  out  D_WIDTH  stream data.
- Out_Valid  out  1  stream valid.
- Out_Ready  in  1  stream ready; transfer when Out_Valid && Out_Ready at a rising edge.
- Busy  out  1  high in S_READ/S_DRAIN.
- Done  out  1  level, high in S_DONE.

## Operation
- States: S_IDLE, S_READ, S_DRAIN, S_DONE.
- Reset (Rst=0, async): S_IDLE; Addr=0, En=0, RW=0, Out_Data=0, Out_Valid=0, Busy=0, Done=0; FIFO and in-flight flag cleared.
- S_IDLE/S_DONE + Str=1: capture Base/Len, clear Done.
  - Len≠0 → S_READ.
  - Len=0 → S_DONE directly (Done re-asserts next cycle, no En pulse).
- Str while Busy: ignored, no effect on captured Base/Len.
- S_READ: En=1 in a cycle iff remaining>0 and slot free.
  - Slot free means occupancy<2, or occupancy=2 with a pop this cycle.
  - Occupancy = FIFO count + in-flight read (0/1).
  - Each issued read: Addr+1 modulo 2^SA_WIDTH (wrap 31→0 at default), remaining−1, in-flight set.
  - remaining reaching 0 → S_DRAIN.
- In-flight read completes the next edge: Data_O pushed into 2-entry FIFO. Out_Data/Out_Valid show FIFO head (registered).
- S_DRAIN: no En; → S_DONE when FIFO empty and no in-flight.
- Overflow is impossible by the issue rule. Simultaneous push and pop in one cycle keeps count unchanged, order preserved.
- Words are emitted strictly in address order, exactly Len words.

## Timing
- Str sampled at edge E0 → En=1, Addr=Base after E0.
  - SRAM samples at E1.
  - Word captured at E2.
  - Out_Valid=1 after E2. First-word latency is 2 cycles after the Str edge.
- Out_Ready held 1: one word per cycle sustained, En continuous.
- Last word for Len=N: Out_Valid falls after edge E0+N+2. Done rises one cycle after the last transfer edge.
- Out_Ready=0: at most 2 words buffered, En stalls. Out_Data/Out_Valid stay stable until accepted.
- Rst asserted mid-transfer: immediate return to reset values, including Out_Valid=0. Pending data is discarded.

## Test plan
- Preload SRAM[0..31]=0x1000_0000+i. Str, Base=0, Len=32, Out_Ready=1 → 32 words 0x1000_0000..0x1000_001F, back-to-back. First Out_Valid 2 cycles after Str. Done=1 afterwards.
- Base=30, Len=4 → words at addresses 30,31,0,1 in order, exactly 4 transfers.
- Len=8, Out_Ready toggling 1,0,0,1 repeating → 8 distinct in-order words, no duplicates. Out_Data stable while Out_Valid&&!Out_Ready. En never high when occupancy is 2 without a pop.
- Len=0 → no En pulse, Busy stays 0, Done=1 the cycle after Str.
- Str pulsed while Busy with different Base → ignored, original sequence completes.
- Rst=0 after 3 of 10 words → all outputs at reset values immediately.
  - Then Str, Base=5, Len=2 → words 5,6 only.
